// File: rtl/fwd_defs.sv
// Shared definitions for the forwarding scoreboard: bypass select encoding
// and the select-width helper.
package fwd_defs;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    // One code per tracked stage plus the register-file code.
    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source operand against the in-flight writer entries.
// Also flags a hit on a load still sitting in the youngest entry.
module fwd_match
    import fwd_defs::*;
#(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int SEL_W = sel_width(DEPTH)
) (
    input  logic [RA_W-1:0]       src_addr,
    input  logic                  src_used,
    input  logic [DEPTH-1:0]      ent_valid,
    input  logic [DEPTH*RA_W-1:0] ent_dst,
    input  logic                  ent0_is_load,
    output logic [SEL_W-1:0]      sel,
    output logic                  load_hit
);

    logic src_live;

    assign src_live = src_used && (src_addr != '0);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (src_live && ent_valid[i] && (ent_dst[i*RA_W +: RA_W] == src_addr)) begin
                sel = SEL_W'(i + 1);
            end
        end
    end

    assign load_hit = ent0_is_load && (sel == SEL_W'(FWD_MEM));

endmodule

// File: rtl/fwd_scoreboard.sv
// Writer scoreboard downstream of EX: produces per-source bypass selects,
// the load-use stall request and a saturating stall-cycle counter.
module fwd_scoreboard
    import fwd_defs::*;
#(
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16,
    localparam int SEL_W = sel_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hold,
    input  logic                  i_flush,
    input  logic                  i_ex_wr_en,
    input  logic [RA_W-1:0]       i_ex_dst,
    input  logic                  i_ex_is_load,
    input  logic [NSRC*RA_W-1:0]  i_src_addr,
    input  logic [NSRC-1:0]       i_src_used,
    output logic [NSRC*SEL_W-1:0] o_fwd_sel,
    output logic                  o_stall,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_is_load;
    logic [DEPTH*RA_W-1:0] ent_dst;
    logic [NSRC-1:0]       load_hit;
    logic                  stall;
    logic                  ex_valid;
    logic [CNT_W-1:0]      stall_cnt;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        fwd_match #(
            .DEPTH (DEPTH),
            .RA_W  (RA_W),
            .SEL_W (SEL_W)
        ) u_match (
            .src_addr     (i_src_addr[k*RA_W +: RA_W]),
            .src_used     (i_src_used[k]),
            .ent_valid    (ent_valid),
            .ent_dst      (ent_dst),
            .ent0_is_load (ent_is_load[0]),
            .sel          (o_fwd_sel[k*SEL_W +: SEL_W]),
            .load_hit     (load_hit[k])
        );
    end

    // A killed EX instruction cannot stall anything, so flush masks the request.
    assign stall    = (|load_hit) && !i_flush;
    assign ex_valid = i_ex_wr_en && !i_flush && !stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ent_valid   <= '0;
            ent_is_load <= '0;
            stall_cnt   <= '0;
        end else if (!i_hold) begin
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i]              <= ent_valid[i-1];
                ent_is_load[i]            <= ent_is_load[i-1];
                ent_dst[i*RA_W +: RA_W]   <= ent_dst[(i-1)*RA_W +: RA_W];
            end
            ent_valid[0]      <= ex_valid;
            ent_is_load[0]    <= i_ex_is_load;
            ent_dst[0 +: RA_W] <= i_ex_dst;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign o_stall     = stall;
    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed bench for fwd_scoreboard; two builds share stimulus
// and are checked against a history-queue model of recently retired EX writes.
module tb_fwd_scoreboard;

    logic       clk;
    logic       rst, hold, flush, wr, ld;
    logic [4:0] dst;
    logic [4:0] sa [3];
    logic [2:0] su;

    logic [3:0]  sel1;
    logic        stall1;
    logic [15:0] cnt1;
    logic [8:0]  sel2;
    logic        stall2;
    logic [3:0]  cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] d;
        logic       ld;
    } ent_t;

    ent_t h1[$];
    ent_t h2[$];
    int   c1, c2;
    logic es1, es2;

    fwd_scoreboard #(.DEPTH(3), .NSRC(2), .RA_W(5), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_flush(flush),
        .i_ex_wr_en(wr), .i_ex_dst(dst), .i_ex_is_load(ld),
        .i_src_addr({sa[1], sa[0]}), .i_src_used(su[1:0]),
        .o_fwd_sel(sel1), .o_stall(stall1), .o_stall_cnt(cnt1)
    );

    fwd_scoreboard #(.DEPTH(4), .NSRC(3), .RA_W(5), .CNT_W(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_flush(flush),
        .i_ex_wr_en(wr), .i_ex_dst(dst), .i_ex_is_load(ld),
        .i_src_addr({sa[2], sa[1], sa[0]}), .i_src_used(su),
        .o_fwd_sel(sel2), .o_stall(stall2), .o_stall_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Register-file code when nothing younger than the register file writes a.
    function automatic int msel(input ent_t h[$], input logic u, input logic [4:0] a);
        if (!u || a == 5'd0) return 0;
        for (int i = 0; i < h.size(); i++)
            if (h[i].v && h[i].d == a) return i + 1;
        return 0;
    endfunction

    task automatic clear_models();
        h1 = {};
        h2 = {};
        repeat (3) h1.push_back('0);
        repeat (4) h2.push_back('0);
        c1 = 0;
        c2 = 0;
    endtask

    task automatic check_outputs();
        int s;
        es1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s = msel(h1, su[k], sa[k]);
            if (s == 1 && h1[0].ld) es1 = 1'b1;
            else chk($sformatf("sel1_%0d", k), int'(sel1[k*2 +: 2]), s);
        end
        if (flush) es1 = 1'b0;
        es2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s = msel(h2, su[k], sa[k]);
            if (s == 1 && h2[0].ld) es2 = 1'b1;
            else chk($sformatf("sel2_%0d", k), int'(sel2[k*3 +: 3]), s);
        end
        if (flush) es2 = 1'b0;
        chk("stall1", int'(stall1), int'(es1));
        chk("stall2", int'(stall2), int'(es2));
        chk("cnt1", int'(cnt1), c1);
        chk("cnt2", int'(cnt2), c2);
    endtask

    task automatic drv(input logic r, input logic hd, input logic fl, input logic w,
                       input logic l, input logic [4:0] d,
                       input logic [4:0] a0, input logic u0,
                       input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2 = 5'd0, input logic u2 = 1'b0);
        rst = r; hold = hd; flush = fl; wr = w; ld = l; dst = d;
        sa[0] = a0; sa[1] = a1; sa[2] = a2;
        su = {u2, u1, u0};
        #4;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            clear_models();
        end else if (!hold) begin
            h1.push_front('{v: wr && !flush && !es1, d: dst, ld: ld});
            void'(h1.pop_back());
            h2.push_front('{v: wr && !flush && !es2, d: dst, ld: ld});
            void'(h2.pop_back());
            if (es1 && c1 < 65535) c1++;
            if (es2 && c2 < 15) c2++;
        end
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst = 1; hold = 0; flush = 0; wr = 0; ld = 0; dst = 0;
        sa[0] = 0; sa[1] = 0; sa[2] = 0; su = 0;
        es1 = 0; es2 = 0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;

        // reset state
        drv(0, 0, 0, 0, 0, 0, 5, 1, 7, 1);
        chk("rst_sel1", int'(sel1), 0);
        chk("rst_stall1", int'(stall1), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        tick();

        // ALU result forwarded from MEM then WB
        drv(0, 0, 0, 1, 0, 5, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        chk("alu_mem", int'(sel1[1:0]), 1);
        chk("alu_nostall", int'(stall1), 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        chk("alu_wb", int'(sel1[1:0]), 2);
        tick();

        // load-use on source 1: one stall then WB bypass
        drv(0, 0, 0, 1, 1, 8, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 8, 1);
        chk("lu_stall", int'(stall1), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 8, 1);
        chk("lu_resolved", int'(stall1), 0);
        chk("lu_wb", int'(sel1[3:2]), 2);
        tick();

        // youngest writer wins; r0 never matches
        drv(0, 0, 0, 1, 0, 3, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 0, 3, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        chk("youngest", int'(sel1[1:0]), 1);
        tick();
        drv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("r0_sel", int'(sel1[1:0]), 0);
        chk("r0_stall", int'(stall1), 0);
        tick();

        // hold during a load-use stall
        drv(0, 0, 0, 1, 1, 8, 0, 0, 0, 0); tick();
        repeat (3) begin
            drv(0, 1, 0, 0, 0, 0, 8, 1, 0, 0);
            chk("hold_stall", int'(stall1), 1);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
        chk("hold_release", int'(stall1), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
        chk("hold_done", int'(stall1), 0);
        chk("hold_wb", int'(sel1[1:0]), 2);
        tick();

        // flushed writer is a bubble
        drv(0, 0, 1, 1, 0, 4, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
        chk("flush_sel", int'(sel1[1:0]), 0);
        tick();

        // reset mid-stall discards the load
        drv(0, 0, 0, 1, 1, 9, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        chk("rst_mid_stall", int'(stall1), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        chk("post_rst_stall", int'(stall1), 0);
        chk("post_rst_cnt", int'(cnt1), 0);
        tick();

        // counter saturation on the CNT_W=4 build: 20 stalls in 40 cycles
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        repeat (40) begin
            drv(0, 0, 0, 1, 1, 8, 8, 1, 0, 0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt2", int'(cnt2), 15);
        chk("cnt1_20", int'(cnt1), 20);
        tick();

        // writer four stages old on the DEPTH=4 build
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 0, 6, 0, 0, 0, 0); tick();
        repeat (3) idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1);
        chk("old4_sel2", int'(sel2[8:6]), 4);
        chk("old4_sel1", int'(sel1), 0);
        tick();

        // randomized traffic over a small register range to force collisions
        repeat (600) begin
            drv($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 5)),
                5'($urandom_range(0, 5)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 5)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, meaning number of in-flight writer stages tracked downstream of EX (entry 0 = MEM, entry 1 = WB, and so on).
REQ-002 Parameter NSRC, default 2, meaning number of source operands checked per cycle.
REQ-003 Parameter RA_W, default 5, meaning register address width.
REQ-004 Parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 Clocking is fixed: one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-006 i_clk  in  1  pipeline clock.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_hold  in  1  global pipeline freeze; scoreboard state holds.
REQ-009 i_flush  in  1  kill the instruction leaving EX this cycle.
REQ-010 i_ex_wr_en  in  1  instruction in EX writes a register.
REQ-011 i_ex_dst  in  RA_W  destination register of the EX instruction, already resolved from rt/rd/31.
REQ-012 i_ex_is_load  in  1  EX instruction is a load; its result is ready only at WB.
REQ-013 i_src_addr  in  NSRC*RA_W  source register addresses in EX; source k occupies slice k.
REQ-014 i_src_used  in  NSRC  per-source flag; 0 means the operand is an immediate or unused.
REQ-015 o_fwd_sel  out  NSRC*SEL_W  per-source bypass select, where SEL_W = clog2(DEPTH+1).
REQ-016 o_stall  out  1  load-use stall request to fetch, decode and EX.
REQ-017 o_stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 The block SHALL hold DEPTH entries, each {valid, dst, is_load}.
REQ-019 Shift rule: on a clock edge with i_hold=0, entry[i] SHALL take entry[i-1] for i>=1, and entry[0] SHALL take the EX instruction.
REQ-020 The EX instruction SHALL be loaded into entry[0] as a bubble (valid=0) when i_flush=1, o_stall=1, or i_ex_wr_en=0.
REQ-021 On a clock edge with i_hold=1, all entries SHALL hold their values; i_hold has priority over flush and stall.
REQ-022 Match rule: source k SHALL match entry i when i_src_used[k]=1, entry[i].valid=1, entry[i].dst equals source k's address, and that address is nonzero.
REQ-023 o_fwd_sel[k] SHALL equal i+1 for the lowest matching index i, and 0 (register file) when nothing matches.
REQ-024 o_fwd_sel SHALL be combinational from current state and inputs, with zero-cycle latency.
REQ-025 o_stall SHALL be 1 when any source's lowest match is entry[0] and entry[0].is_load=1.
REQ-026 During a stall, the o_fwd_sel value for the stalled source is don't-care.
REQ-027 A load-use dependency SHALL produce exactly one stall cycle; after the shift the load sits in entry[1] and is forwarded with sel=2.
REQ-028 o_stall SHALL be forced to 0 while i_flush=1.
REQ-029 o_stall_cnt SHALL increment on each edge where o_stall=1 and i_hold=0.
REQ-030 o_stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 Register 0 SHALL never match and never stall.
REQ-032 A dst match in several entries SHALL resolve to the youngest (lowest index) entry.

Reset
REQ-033 When i_rst=1 at an edge, all entry valid bits SHALL clear, and o_stall_cnt SHALL clear to 0.
REQ-034 i_rst SHALL dominate i_hold and i_flush.
REQ-035 While all entries are invalid (including the cycle after reset), o_fwd_sel SHALL be 0 and o_stall SHALL be 0.
REQ-036 Reset asserted mid-stall SHALL discard the pending load.

Structure
REQ-037 The shared definitions file fwd_defs SHALL hold the select encoding constants (FWD_RF=0, FWD_MEM=1, FWD_WB=2) and the SEL_W computation.
REQ-038 One sub-module, fwd_match, SHALL implement the per-source priority match.
REQ-039 fwd_match SHALL be instantiated NSRC times, with DEPTH as its parameter.

Verification
REQ-040 Cycle 0: EX "add dst=5". Cycle 1: src0=5 used. Required: o_fwd_sel[0]=1 and o_stall=0. Cycle 2 with src0=5: o_fwd_sel[0]=2.
REQ-041 Cycle 0: EX "lw dst=8". Cycle 1: src1=8 used. Required: o_stall=1 for one cycle, then o_fwd_sel[1]=2 and o_stall=0. o_stall_cnt goes 0->1.
REQ-042 Writes to r3 on two consecutive cycles, then src0=3. Required: o_fwd_sel[0]=1 (youngest wins). Writes to r0, then src0=0. Required: o_fwd_sel[0]=0.
REQ-043 Load to r8 in entry[0] with src=8 and i_hold=1 for 3 cycles. Required: o_stall stays 1, o_stall_cnt unchanged, entries unchanged. After i_hold drops: stall resolves in 1 cycle.
REQ-044 i_flush=1 with an EX write to r4, then src=4. Required: o_fwd_sel=0. i_rst=1 mid-stall. Required: o_stall=0 and o_stall_cnt=0 on the next cycle.
REQ-045 Build with CNT_W=4 and force 20 stall cycles. Required: o_stall_cnt reads 15. Repeat with DEPTH=4, NSRC=3 and a writer 4 stages old. Required: o_fwd_sel=4.
